// File: rtl/cmsdk_fpga_sram_spi_preload_pkg.sv
// Shared types and constants for the SPI flash to SRAM boot preloader.
// Holds the READ opcode, header width, FSM encoding and the byte packer.
package cmsdk_fpga_sram_spi_preload_pkg;

  localparam logic [7:0] SPI_READ_OPCODE = 8'h03;
  localparam int         HDR_W           = 32;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    FINISH
  } state_t;

  // The first flash byte arrives MSB-first in rx[31:24]
  // and must land in lane 0 of the SRAM word.
  function automatic logic [31:0] pack_le(input logic [31:0] rx);
    return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  endfunction

endpackage

// File: rtl/cmsdk_fpga_sram_spi_shift.sv
// SPI mode-0 clock divider and 32-bit shift register.
// Ports: clk/rst, run (SCK enable), load/load_data (header preset),
//   tx_en (drive header on MOSI), miso in; sck, mosi, sck_rise/sck_fall
//   strobes (the CLK edge that moves SCK), bit_cnt (rises mod 32),
//   rx_word (register contents including the bit sampled this edge).
module cmsdk_fpga_sram_spi_shift
  import cmsdk_fpga_sram_spi_preload_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [HDR_W-1:0] load_data,
  input  logic             tx_en,
  input  logic             miso,
  output logic             sck,
  output logic             mosi,
  output logic             sck_rise,
  output logic             sck_fall,
  output logic [4:0]       bit_cnt,
  output logic [HDR_W-1:0] rx_word
);

  localparam int DW = $clog2(CLKDIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  logic [DW-1:0]    div_q, div_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic [HDR_W-1:0] sr_q, sr_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             tick;

  assign tick     = run && (div_q == DIV_LAST);
  assign sck_rise = tick && !sck_q;
  assign sck_fall = tick && sck_q;
  assign rx_word  = {sr_q[HDR_W-2:0], miso};

  always_comb begin
    div_d  = div_q;
    sck_d  = sck_q;
    mosi_d = mosi_q;
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    if (load) begin
      div_d  = '0;
      sck_d  = 1'b0;
      sr_d   = load_data;
      mosi_d = load_data[HDR_W-1];
      cnt_d  = '0;
    end else if (!run) begin
      div_d  = '0;
      sck_d  = 1'b0;
      mosi_d = 1'b0;
    end else begin
      div_d = tick ? '0 : div_q + DW'(1);
      if (tick) sck_d = !sck_q;
      if (sck_rise) begin
        sr_d  = rx_word;
        cnt_d = cnt_q + 5'd1;
      end
      // sr_q[31] already holds the next header bit after the
      // preceding rise, so MOSI only moves while SCK falls.
      if (sck_fall) mosi_d = tx_en ? sr_q[HDR_W-1] : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
      sr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      div_q  <= div_d;
      sck_q  <= sck_d;
      mosi_q <= mosi_d;
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign bit_cnt = cnt_q;

endmodule

// File: rtl/cmsdk_fpga_sram_spi_preload.sv
// Boot preloader: READs 2**AW words from SPI flash into SRAM, then
// releases CPU_HOLD. Ports: CLK/RESET/START; SPI_SCK/CSN/MOSI/MISO;
// SRAM_ADDR/WDATA/WREN/CS write port; BUSY, DONE (sticky), CPU_HOLD.
// Define SRAM_PRELOAD_CHECKSUM_EN to add the CHECKSUM[31:0] output.
module cmsdk_fpga_sram_spi_preload
  import cmsdk_fpga_sram_spi_preload_pkg::*;
#(
  parameter int          AW         = 16,
  parameter int          CLKDIV     = 4,
  parameter logic [23:0] FLASH_BASE = 24'h000000
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  output logic          SPI_SCK,
  output logic          SPI_CSN,
  output logic          SPI_MOSI,
  input  logic          SPI_MISO,
  output logic [AW-1:0] SRAM_ADDR,
  output logic [31:0]   SRAM_WDATA,
  output logic [3:0]    SRAM_WREN,
  output logic          SRAM_CS,
  output logic          BUSY,
  output logic          DONE,
  output logic          CPU_HOLD
`ifdef SRAM_PRELOAD_CHECKSUM_EN
  ,
  output logic [31:0]   CHECKSUM
`endif
);

  localparam logic [HDR_W-1:0] HEADER = {SPI_READ_OPCODE, FLASH_BASE};

  state_t        state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          cs_q, cs_d;
  logic          last_q, last_d;
  logic          done_q, done_d;

  logic          run, load, tx_en;
  logic          sck_rise, sck_fall;
  logic [4:0]    bit_cnt;
  logic [31:0]   rx_word;
  logic          word_done, wr_fire;

  assign run       = (state_q == CMD) || (state_q == DATA);
  assign load      = (state_q == IDLE) && START;
  assign tx_en     = (state_q == CMD);
  assign word_done = sck_rise && (bit_cnt == 5'd31);
  assign wr_fire   = (state_q == DATA) && word_done && !last_q;

  cmsdk_fpga_sram_spi_shift #(
    .CLKDIV(CLKDIV)
  ) u_shift (
    .clk      (CLK),
    .rst      (RESET),
    .run      (run),
    .load     (load),
    .load_data(HEADER),
    .tx_en    (tx_en),
    .miso     (SPI_MISO),
    .sck      (SPI_SCK),
    .mosi     (SPI_MOSI),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .bit_cnt  (bit_cnt),
    .rx_word  (rx_word)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cs_d    = 1'b0;
    last_d  = last_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = CMD;
          wcnt_d  = '0;
          last_d  = 1'b0;
          done_d  = 1'b0;
        end
      end
      CMD: begin
        if (word_done) state_d = DATA;
      end
      DATA: begin
        if (wr_fire) begin
          cs_d    = 1'b1;
          addr_d  = wcnt_q;
          wdata_d = pack_le(rx_word);
          if (wcnt_q == {AW{1'b1}}) last_d = 1'b1;
          else wcnt_d = wcnt_q + 1'b1;
        end
        // Let the final SCK high phase complete so the last
        // bit still sees a full clock on the pin.
        if (last_q && sck_fall) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cs_q    <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cs_q    <= cs_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign SPI_CSN    = !run;
  assign BUSY       = run;
  assign DONE       = done_q;
  assign CPU_HOLD   = !done_q;
  assign SRAM_CS    = cs_q;
  assign SRAM_WREN  = {4{cs_q}};
  assign SRAM_ADDR  = addr_q;
  assign SRAM_WDATA = wdata_q;

`ifdef SRAM_PRELOAD_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (load) csum_d = '0;
    else if (wr_fire) csum_d = csum_q + pack_le(rx_word);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) csum_q <= '0;
    else csum_q <= csum_d;
  end

  assign CHECKSUM = csum_q;
`endif

endmodule

// File: tb/tb_cmsdk_fpga_sram_spi_preload.sv
// Scoreboard bench for the SPI flash to SRAM preloader (AW=2, CLKDIV=2).
// A flash model serves bytes 0x00..0x0F; a monitor checks SRAM writes.
module tb_cmsdk_fpga_sram_spi_preload;

  localparam int AW     = 2;
  localparam int CLKDIV = 2;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          START;
  logic          SPI_SCK, SPI_CSN, SPI_MOSI;
  logic          SPI_MISO = 1'b0;
  logic [AW-1:0] SRAM_ADDR;
  logic [31:0]   SRAM_WDATA;
  logic [3:0]    SRAM_WREN;
  logic          SRAM_CS, BUSY, DONE, CPU_HOLD;
`ifdef SRAM_PRELOAD_CHECKSUM_EN
  logic [31:0]   CHECKSUM;
`endif

  always #5 CLK = ~CLK;

  cmsdk_fpga_sram_spi_preload #(
    .AW        (AW),
    .CLKDIV    (CLKDIV),
    .FLASH_BASE(24'h000000)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .SPI_SCK   (SPI_SCK),
    .SPI_CSN   (SPI_CSN),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_MISO  (SPI_MISO),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_WDATA(SRAM_WDATA),
    .SRAM_WREN (SRAM_WREN),
    .SRAM_CS   (SRAM_CS),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .CPU_HOLD  (CPU_HOLD)
`ifdef SRAM_PRELOAD_CHECKSUM_EN
    ,
    .CHECKSUM  (CHECKSUM)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // flash model: captures the header, serves mem[] MSB first
  logic [7:0]  mem [0:255];
  int          bitn = 0;
  logic [31:0] hdr_sh = '0;
  int          fl_idx, fl_byte, fl_bit;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = (i < 16) ? 8'(i) : 8'hFF;
  end

  always @(negedge SPI_CSN) begin
    bitn = 0;
  end

  always @(posedge SPI_SCK) begin
    if (!SPI_CSN) begin
      if (bitn < 32) begin
        hdr_sh = {hdr_sh[30:0], SPI_MOSI};
        if (bitn == 31) check("mosi_header", hdr_sh, 32'h03000000);
      end
      bitn++;
    end
  end

  always @(negedge SPI_SCK) begin
    if (!SPI_CSN && bitn >= 32) begin
      fl_idx  = bitn - 32;
      fl_byte = (int'(hdr_sh[23:0]) + fl_idx / 8) % 256;
      fl_bit  = 7 - (fl_idx % 8);
      SPI_MISO = mem[fl_byte][fl_bit];
    end
  end

  // SCK timing monitor
  int cyc = 0;
  int rise_cnt = 0;
  int last_rise = 0;
  int period_bad = 0;

  always @(posedge CLK) cyc++;

  always @(posedge SPI_SCK) begin
    if (!SPI_CSN) begin
      if (rise_cnt > 0 && (cyc - last_rise) != 2 * CLKDIV) period_bad++;
      last_rise = cyc;
      rise_cnt++;
    end
  end

  // SRAM scoreboard monitor plus MOSI stability tracking
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  e;
  int   wr_cnt = 0;
  int   wren_bad = 0;
  int   mosi_bad = 0;
  logic prev_cs = 1'b0;
  logic prev_mosi = 1'b0;
  logic prev_sck = 1'b0;

  always @(negedge CLK) begin
    if (SRAM_CS === 1'b1) begin
      wr_cnt++;
      check("sram_cs_single_cycle", 32'(prev_cs), 32'h0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write addr=%0d data=%h", SRAM_ADDR,
                 SRAM_WDATA);
      end else begin
        e = exp_q.pop_front();
        check("sram_addr", 32'(SRAM_ADDR), 32'(e.addr));
        check("sram_wdata", SRAM_WDATA, e.data);
        check("sram_wren", 32'(SRAM_WREN), 32'hF);
      end
    end else if (SRAM_WREN !== 4'h0) begin
      wren_bad++;
    end
    if (!SPI_CSN && SPI_MOSI !== prev_mosi && !(prev_sck && !SPI_SCK))
      mosi_bad++;
    prev_cs   = SRAM_CS;
    prev_mosi = SPI_MOSI;
    prev_sck  = SPI_SCK;
  end

  task automatic push_words(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      exp_q.push_back('{addr: AW'(i), data: w});
    end
  endtask

  task automatic clear_run();
    rise_cnt   = 0;
    period_bad = 0;
    mosi_bad   = 0;
    wr_cnt     = 0;
    wren_bad   = 0;
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1;
    check("start_busy", 32'(BUSY), 32'h1);
    check("start_csn", 32'(SPI_CSN), 32'h0);
    check("start_done_clear", 32'(DONE), 32'h0);
    check("start_cpu_hold", 32'(CPU_HOLD), 32'h1);
`ifdef SRAM_PRELOAD_CHECKSUM_EN
    check("start_checksum_clear", CHECKSUM, 32'h0);
`endif
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic run_to_done(input int restart_at);
    bit sent;
    sent = 0;
    for (int i = 0; i < 4000 && DONE !== 1'b1; i++) begin
      @(negedge CLK);
      START = 1'b0;
      if (restart_at > 0 && !sent && rise_cnt >= restart_at) begin
        START = 1'b1;
        sent  = 1;
      end
    end
    START = 1'b0;
    check("done_reached", 32'(DONE), 32'h1);
  endtask

  task automatic post_checks();
    check("end_cpu_hold", 32'(CPU_HOLD), 32'h0);
    check("end_busy", 32'(BUSY), 32'h0);
    check("end_csn", 32'(SPI_CSN), 32'h1);
    check("end_sck", 32'(SPI_SCK), 32'h0);
    check("sck_rise_count", 32'(rise_cnt), 32'd160);
    check("sck_period", 32'(period_bad), 32'h0);
    check("mosi_stable", 32'(mosi_bad), 32'h0);
    check("write_count", 32'(wr_cnt), 32'd4);
    check("writes_pending", 32'(exp_q.size()), 32'h0);
    check("wren_idle", 32'(wren_bad), 32'h0);
`ifdef SRAM_PRELOAD_CHECKSUM_EN
    check("checksum_done", CHECKSUM, 32'h24201C18);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_csn"}, 32'(SPI_CSN), 32'h1);
    check({tag, "_sck"}, 32'(SPI_SCK), 32'h0);
    check({tag, "_mosi"}, 32'(SPI_MOSI), 32'h0);
    check({tag, "_sram_cs"}, 32'(SRAM_CS), 32'h0);
    check({tag, "_wren"}, 32'(SRAM_WREN), 32'h0);
    check({tag, "_addr"}, 32'(SRAM_ADDR), 32'h0);
    check({tag, "_wdata"}, SRAM_WDATA, 32'h0);
    check({tag, "_busy"}, 32'(BUSY), 32'h0);
    check({tag, "_done"}, 32'(DONE), 32'h0);
    check({tag, "_cpu_hold"}, 32'(CPU_HOLD), 32'h1);
`ifdef SRAM_PRELOAD_CHECKSUM_EN
    check({tag, "_checksum"}, CHECKSUM, 32'h0);
`endif
  endtask

  int idle_bad;

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    idle_bad = 0;
    repeat (100) begin
      @(negedge CLK);
      if ({SPI_CSN, SPI_SCK, SRAM_CS, SRAM_WREN, BUSY, DONE, CPU_HOLD}
          !== 10'b10_0000_0001) idle_bad++;
    end
    check("idle_hold_100", 32'(idle_bad), 32'h0);
    check_reset_vals("idle");

    clear_run();
    push_words(4);
    pulse_start();
    run_to_done(0);
    post_checks();

    clear_run();
    push_words(4);
    pulse_start();
    run_to_done(50);
    post_checks();

    clear_run();
    push_words(2);
    pulse_start();
    for (int i = 0; i < 2000 && wr_cnt < 2; i++) @(negedge CLK);
    check("pre_reset_writes", 32'(wr_cnt), 32'd2);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    check_reset_vals("midreset");
    repeat (5) @(negedge CLK);
    RESET = 1'b0;
    repeat (200) @(negedge CLK);
    check("no_partial_write", 32'(wr_cnt), 32'd2);
    check("post_reset_done", 32'(DONE), 32'h0);

    clear_run();
    push_words(4);
    pulse_start();
    run_to_done(0);
    post_checks();

    repeat (5) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
